lens_table_controller: RTL and testbench
========================================

LENS_TABLE_CONTROLLER -- requirements
Module: lens_table_controller

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- IMG_WIDTH, 320, image width in pixels.
- IMG_HEIGHT, 240, image height in pixels.
- MAX_LENS, 8, table depth.
- STEP, 2, position step in pixels.
- R_MIN, 8, minimum radius.
- R_MAX, 100, maximum radius.
- R_INIT, 32, initial radius.
- K_INIT, 4, initial strength.
- REPEAT_DLY, 25000000, hold cycles before auto-repeat.
- REPEAT_PER, 5000000, auto-repeat period in cycles.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, system clock.
- reset, in, 1, reset.
- frame_start, in, 1, one-cycle pulse at vertical blank.
- sw0_edit_mode, in, 1, edit mode enable.
- sw1_adjust, in, 1, 1 = buttons adjust R/K, 0 = buttons move center.
- btn_up, btn_down, btn_left, btn_right, in, 1 each, debounced levels.
- btn_commit, in, 1, debounced level; store the current lens.
- btn_clear, in, 1, debounced level; empty the table.
- current_center_x, out, 9, preview lens center x.
- current_center_y, out, 8, preview lens center y.
- current_R, out, 8, preview lens radius.
- current_K, out, 8, preview lens strength.
- preview_enable, out, 1, preview lens is displayed.
- lens_count, out, 3, number of valid table entries.
- lens_center_x[0:MAX_LENS-1], out, 9 each, stored centers x.
- lens_center_y[0:MAX_LENS-1], out, 8 each, stored centers y.
- lens_R[0:MAX_LENS-1], out, 8 each, stored radii.
- lens_K[0:MAX_LENS-1], out, 8 each, stored strengths.
- busy, out, 1, an edit is pending until the next frame_start.

REQ-003 Reset SHALL be reset, asynchronous, active-high; the clock SHALL be clk.

Function
REQ-004 Each button SHALL produce an internal action pulse on its rising edge. While the button stays held, it SHALL produce a further pulse after REPEAT_DLY cycles and then one every REPEAT_PER cycles. btn_commit and btn_clear SHALL NOT auto-repeat.

REQ-005 The FSM SHALL have the states VIEW, EDIT, COMMIT and CLEAR.
- VIEW -> EDIT when sw0_edit_mode=1.
- EDIT -> VIEW when sw0_edit_mode=0.
- EDIT -> COMMIT on a commit pulse.
- VIEW or EDIT -> CLEAR on a clear pulse.
- COMMIT and CLEAR SHALL each wait for frame_start, perform their write in that cycle, then return to the mode selected by sw0_edit_mode.

REQ-006 In EDIT with sw1_adjust=0, the arrow buttons SHALL move the working center by STEP.
- x SHALL be clamped to [0, IMG_WIDTH-1] and y to [0, IMG_HEIGHT-1], saturating and never wrapping.

REQ-007 In EDIT with sw1_adjust=1:
- up/down SHALL change R by ±1, saturating at R_MIN..R_MAX.
- right/left SHALL change K by ±1, saturating at 0..15.

REQ-008 Working-register changes SHALL be copied to the current_* outputs only in a cycle where frame_start=1, so a single frame never shows two lens geometries.

REQ-009 preview_enable SHALL be 1 only in EDIT, COMMIT and CLEAR, and SHALL only change on frame_start.

REQ-010 In COMMIT, when lens_count<7:
- the current lens SHALL be written into entry lens_count, and lens_count SHALL be incremented.
- the working center SHALL be kept unchanged.
- entries at index ≥ lens_count SHALL read zero.

REQ-011 The table is full at lens_count=7, the maximum a 3-bit count can express.
- A commit when full SHALL be dropped with no state change.
- Entry MAX_LENS-1 SHALL be permanently zero.

REQ-012 In CLEAR, lens_count SHALL become 0 and all entries SHALL be zeroed. The current lens SHALL be unchanged.

REQ-013 Commit and clear pulses arriving while COMMIT or CLEAR is pending SHALL be ignored. If commit and clear are pulsed in the same cycle, clear SHALL win.

REQ-014 busy SHALL be 1 from a pending edit or state change until the frame_start that applies it, inclusive.

REQ-015 Latency from a button action to the outputs SHALL be 1 cycle plus the wait to the next frame_start. If frame_start coincides with an action pulse, that action SHALL apply at the following frame_start.

Reset
REQ-016 On reset the block SHALL enter VIEW with:
- current_center_x=IMG_WIDTH/2 and current_center_y=IMG_HEIGHT/2.
- current_R=R_INIT and current_K=K_INIT.
- preview_enable=0, busy=0, lens_count=0, all entries zero.
- repeat counters and edge registers cleared.

REQ-017 A reset asserted mid-COMMIT SHALL leave no partial entry.

Structure
REQ-018 A shared package lens_pkg SHALL hold:
- the lens_t struct {cx[8:0], cy[7:0], R[7:0], K[7:0]};
- the state enum;
- the IMG_WIDTH, IMG_HEIGHT and MAX_LENS defaults.

REQ-019 Edge detection and auto-repeat SHALL be a sub-module btn_repeat, instantiated once per button with the repeat option selectable.

Verification (REPEAT_DLY=10, REPEAT_PER=4)
REQ-020 Edit, right pulse ×3, then frame_start -> current_center_x=166, preview_enable=1.

REQ-021 Hold left from x=4 for 40 cycles, then frame_start -> x=0 with no wrap. Repeat pulses occur at hold cycles 10, 14, 18, ….

REQ-022 Commit 8 times, each followed by frame_start -> lens_count=7, and entries 0..6 hold the committed values.

REQ-023 Commit and clear in the same cycle, then frame_start -> lens_count=0 and all entries zero.

REQ-024 Assert reset while COMMIT is waiting for frame_start -> all reset values hold, lens_count=0 and busy=0.

Source files
------------

// File: rtl/lens_pkg.sv
// Shared types for the lens table controller: lens record, FSM states, image/table defaults.
package lens_pkg;

    localparam int DEF_IMG_WIDTH  = 320;
    localparam int DEF_IMG_HEIGHT = 240;
    localparam int DEF_MAX_LENS   = 8;

    typedef struct packed {
        logic [8:0] cx;
        logic [7:0] cy;
        logic [7:0] R;
        logic [7:0] K;
    } lens_t;

    typedef enum logic [1:0] {
        ST_VIEW   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_CLEAR  = 2'd3
    } state_t;

endpackage

// File: rtl/btn_repeat.sv
// Button edge detector with optional auto-repeat: combinational pulse in the cycle the
// level first reads high, then after DLY held cycles and every PER cycles after that.
module btn_repeat #(
    parameter bit REPEAT_EN = 1'b1,
    parameter int DLY       = 25000000,
    parameter int PER       = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int            CW       = $clog2(DLY + 1);
    localparam logic [CW-1:0] DLY_C    = CW'(DLY);
    localparam logic [CW-1:0] RELOAD_C = CW'(DLY - PER + 1);

    logic          btn_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rep_hit;

    // cnt_q equals the number of cycles the button has been held, until the first repeat
    assign rep_hit = REPEAT_EN && btn_i && btn_q && (cnt_q == DLY_C);
    assign pulse_o = (btn_i && !btn_q) || rep_hit;

    always_comb begin
        cnt_d = cnt_q;
        if (!btn_i || !REPEAT_EN)
            cnt_d = '0;
        else if (!btn_q)
            cnt_d = CW'(1);
        else if (rep_hit)
            cnt_d = RELOAD_C;
        else
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            btn_q <= btn_i;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lens_table_controller.sv
// Lens editor and table: buttons edit a working lens, frame_start publishes it and applies
// commit/clear, so outputs change one cycle after an action plus the wait to frame_start.
module lens_table_controller import lens_pkg::*; #(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int MAX_LENS   = DEF_MAX_LENS,
    parameter int STEP       = 2,
    parameter int R_MIN      = 8,
    parameter int R_MAX      = 100,
    parameter int R_INIT     = 32,
    parameter int K_INIT     = 4,
    parameter int REPEAT_DLY = 25000000,
    parameter int REPEAT_PER = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       sw0_edit_mode,
    input  logic       sw1_adjust,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_commit,
    input  logic       btn_clear,
    output logic [8:0] current_center_x,
    output logic [7:0] current_center_y,
    output logic [7:0] current_R,
    output logic [7:0] current_K,
    output logic       preview_enable,
    output logic [2:0] lens_count,
    output logic [8:0] lens_center_x [0:MAX_LENS-1],
    output logic [7:0] lens_center_y [0:MAX_LENS-1],
    output logic [7:0] lens_R        [0:MAX_LENS-1],
    output logic [7:0] lens_K        [0:MAX_LENS-1],
    output logic       busy
);

    localparam logic [9:0] X_MAX   = 10'(IMG_WIDTH - 1);
    localparam logic [9:0] Y_MAX   = 10'(IMG_HEIGHT - 1);
    localparam logic [9:0] STEP_C  = 10'(STEP);
    localparam logic [7:0] R_MIN_C = 8'(R_MIN);
    localparam logic [7:0] R_MAX_C = 8'(R_MAX);
    // Usable depth is bounded both by the 3-bit count and by keeping the last entry empty
    localparam logic [2:0] CAP     = (MAX_LENS - 1 < 7) ? 3'(MAX_LENS - 1) : 3'd7;
    localparam lens_t      LENS_RST = '{cx: 9'(IMG_WIDTH / 2), cy: 8'(IMG_HEIGHT / 2),
                                        R: 8'(R_INIT), K: 8'(K_INIT)};

    logic   up_p, dn_p, lf_p, rt_p, cm_p, cl_p;
    state_t state_q, state_d;
    lens_t  work_q, work_d, cur_q, cur_d;
    lens_t  tbl_q [MAX_LENS];
    lens_t  tbl_d [MAX_LENS];
    logic [2:0] count_q, count_d;
    logic   prev_q, prev_d, pend_q, pend_d, busy_q, busy_d, full;
    logic [9:0] x_w, y_w, x_inc, y_inc;

    btn_repeat #(.REPEAT_EN(1'b1), .DLY(REPEAT_DLY), .PER(REPEAT_PER)) u_up (.clk(clk), .reset(reset), .btn_i(btn_up),     .pulse_o(up_p));
    btn_repeat #(.REPEAT_EN(1'b1), .DLY(REPEAT_DLY), .PER(REPEAT_PER)) u_dn (.clk(clk), .reset(reset), .btn_i(btn_down),   .pulse_o(dn_p));
    btn_repeat #(.REPEAT_EN(1'b1), .DLY(REPEAT_DLY), .PER(REPEAT_PER)) u_lf (.clk(clk), .reset(reset), .btn_i(btn_left),   .pulse_o(lf_p));
    btn_repeat #(.REPEAT_EN(1'b1), .DLY(REPEAT_DLY), .PER(REPEAT_PER)) u_rt (.clk(clk), .reset(reset), .btn_i(btn_right),  .pulse_o(rt_p));
    btn_repeat #(.REPEAT_EN(1'b0), .DLY(REPEAT_DLY), .PER(REPEAT_PER)) u_cm (.clk(clk), .reset(reset), .btn_i(btn_commit), .pulse_o(cm_p));
    btn_repeat #(.REPEAT_EN(1'b0), .DLY(REPEAT_DLY), .PER(REPEAT_PER)) u_cl (.clk(clk), .reset(reset), .btn_i(btn_clear),  .pulse_o(cl_p));

    assign x_w   = {1'b0, work_q.cx};
    assign y_w   = {2'b0, work_q.cy};
    assign x_inc = x_w + STEP_C;
    assign y_inc = y_w + STEP_C;
    assign full  = (count_q >= CAP);

    always_comb begin
        work_d  = work_q;
        state_d = state_q;
        tbl_d   = tbl_q;
        count_d = count_q;
        cur_d   = cur_q;
        prev_d  = prev_q;
        pend_d  = pend_q;

        if (state_q == ST_EDIT && !sw1_adjust) begin
            if (rt_p)      work_d.cx = (x_inc > X_MAX) ? X_MAX[8:0] : x_inc[8:0];
            else if (lf_p) work_d.cx = (x_w < STEP_C) ? 9'd0 : 9'(x_w - STEP_C);
            if (dn_p)      work_d.cy = (y_inc > Y_MAX) ? Y_MAX[7:0] : y_inc[7:0];
            else if (up_p) work_d.cy = (y_w < STEP_C) ? 8'd0 : 8'(y_w - STEP_C);
        end else if (state_q == ST_EDIT) begin
            if (up_p && work_q.R < R_MAX_C)      work_d.R = work_q.R + 8'd1;
            else if (dn_p && work_q.R > R_MIN_C) work_d.R = work_q.R - 8'd1;
            if (rt_p && work_q.K < 8'd15)        work_d.K = work_q.K + 8'd1;
            else if (lf_p && work_q.K > 8'd0)    work_d.K = work_q.K - 8'd1;
        end

        case (state_q)
            ST_VIEW: begin
                if (cl_p)               state_d = ST_CLEAR;
                else if (sw0_edit_mode) state_d = ST_EDIT;
            end
            ST_EDIT: begin
                if (cl_p)                state_d = ST_CLEAR;
                else if (cm_p && !full)  state_d = ST_COMMIT;
                else if (!sw0_edit_mode) state_d = ST_VIEW;
            end
            ST_COMMIT: begin
                if (frame_start) begin
                    if (!full) begin
                        for (int i = 0; i < MAX_LENS; i++)
                            if (i == int'(count_q)) tbl_d[i] = work_q;
                        count_d = count_q + 3'd1;
                    end
                    state_d = sw0_edit_mode ? ST_EDIT : ST_VIEW;
                end
            end
            ST_CLEAR: begin
                if (frame_start) begin
                    for (int i = 0; i < MAX_LENS; i++) tbl_d[i] = '0;
                    count_d = 3'd0;
                    state_d = sw0_edit_mode ? ST_EDIT : ST_VIEW;
                end
            end
            default: state_d = ST_VIEW;
        endcase

        // An edit made in the frame_start cycle itself stays pending for the next frame
        if (frame_start) begin
            cur_d  = work_q;
            prev_d = (state_d != ST_VIEW);
            pend_d = (work_d != work_q);
        end else begin
            pend_d = pend_q || (work_d != work_q) || (state_d != state_q);
        end
        busy_d = pend_d || (state_d == ST_COMMIT) || (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_VIEW;
            work_q  <= LENS_RST;
            cur_q   <= LENS_RST;
            count_q <= 3'd0;
            prev_q  <= 1'b0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < MAX_LENS; i++) tbl_q[i] <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cur_q   <= cur_d;
            count_q <= count_d;
            prev_q  <= prev_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            tbl_q   <= tbl_d;
        end
    end

    assign current_center_x = cur_q.cx;
    assign current_center_y = cur_q.cy;
    assign current_R        = cur_q.R;
    assign current_K        = cur_q.K;
    assign preview_enable   = prev_q;
    assign lens_count       = count_q;
    assign busy             = busy_q;

    always_comb begin
        for (int i = 0; i < MAX_LENS; i++) begin
            lens_center_x[i] = tbl_q[i].cx;
            lens_center_y[i] = tbl_q[i].cy;
            lens_R[i]        = tbl_q[i].R;
            lens_K[i]        = tbl_q[i].K;
        end
    end

endmodule

// File: tb/tb_lens_table_controller.sv
// Directed bench for lens_table_controller with short repeat timing (DLY=10, PER=4).
module tb_lens_table_controller;

    localparam int UP = 0, DN = 1, LF = 2, RT = 3, CM = 4, CL = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, frame_start, sw0, sw1;
    logic [5:0] btn;
    logic [8:0] cur_x;
    logic [7:0] cur_y, cur_r, cur_k;
    logic       prev_en, busy;
    logic [2:0] count;
    logic [8:0] lx [0:7];
    logic [7:0] ly [0:7];
    logic [7:0] lr [0:7];
    logic [7:0] lk [0:7];

    int n_tests = 0;
    int n_fail  = 0;

    lens_table_controller #(.REPEAT_DLY(10), .REPEAT_PER(4)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .sw0_edit_mode(sw0), .sw1_adjust(sw1),
        .btn_up(btn[UP]), .btn_down(btn[DN]), .btn_left(btn[LF]), .btn_right(btn[RT]),
        .btn_commit(btn[CM]), .btn_clear(btn[CL]),
        .current_center_x(cur_x), .current_center_y(cur_y),
        .current_R(cur_r), .current_K(cur_k),
        .preview_enable(prev_en), .lens_count(count),
        .lens_center_x(lx), .lens_center_y(ly), .lens_R(lr), .lens_K(lk),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int b);
        btn[b] = 1'b1; cyc(1);
        btn[b] = 1'b0; cyc(1);
    endtask

    task automatic hold(input int b, input int n);
        btn[b] = 1'b1; cyc(n);
        btn[b] = 1'b0; cyc(1);
    endtask

    task automatic frame();
        frame_start = 1'b1; cyc(1);
        frame_start = 1'b0; cyc(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; frame_start = 1'b0; sw0 = 1'b0; sw1 = 1'b0; btn = '0;
        cyc(3);
        chk("rst_cx", 32'(cur_x), 160);
        chk("rst_cy", 32'(cur_y), 120);
        chk("rst_R", 32'(cur_r), 32);
        chk("rst_K", 32'(cur_k), 4);
        chk("rst_prev", 32'(prev_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_e0", 32'(lx[0]), 0);
        reset = 1'b0;
        cyc(2);
        chk("idle_busy", 32'(busy), 0);

        // enter edit, move right three steps
        sw0 = 1'b1; cyc(2);
        chk("edit_busy", 32'(busy), 1);
        chk("edit_prev_before_frame", 32'(prev_en), 0);
        for (int i = 0; i < 3; i++) press(RT);
        chk("cx_held_until_frame", 32'(cur_x), 160);
        frame();
        chk("right3_cx", 32'(cur_x), 166);
        chk("right3_prev", 32'(prev_en), 1);
        chk("right3_busy", 32'(busy), 0);

        // walk to x=4, then hold left past zero
        for (int i = 0; i < 81; i++) press(LF);
        frame();
        chk("walk_cx4", 32'(cur_x), 4);
        hold(LF, 40);
        frame();
        chk("hold_left_sat", 32'(cur_x), 0);

        // repeat cadence: 40 held cycles -> pulses at 0,10,14,...,38 = 9
        sw1 = 1'b1;
        hold(UP, 40);
        frame();
        chk("hold_up_R", 32'(cur_r), 41);
        hold(DN, 200);
        for (int i = 0; i < 5; i++) press(LF);
        frame();
        chk("R_sat_min", 32'(cur_r), 8);
        chk("K_sat_zero", 32'(cur_k), 0);
        for (int i = 0; i < 3; i++) press(RT);
        frame();
        chk("K_up3", 32'(cur_k), 3);
        sw1 = 1'b0;

        // action coinciding with frame_start lands on the following frame
        btn[RT] = 1'b1; frame_start = 1'b1; cyc(1);
        btn[RT] = 1'b0; frame_start = 1'b0; cyc(1);
        chk("coincide_old_cx", 32'(cur_x), 0);
        chk("coincide_busy", 32'(busy), 1);
        frame();
        chk("coincide_new_cx", 32'(cur_x), 2);

        // eight commits, x advanced before each; eighth is dropped
        for (int i = 0; i < 8; i++) begin
            press(RT);
            press(CM);
            if (i == 0) press(CM);
            if (i == 1) chk("commit_busy", 32'(busy), 1);
            frame();
            if (i == 0) chk("double_commit_count", 32'(count), 1);
        end
        chk("full_count", 32'(count), 7);
        for (int i = 0; i < 7; i++) chk($sformatf("entry%0d_cx", i), 32'(lx[i]), 32'(4 + 2 * i));
        chk("entry6_cy", 32'(ly[6]), 120);
        chk("entry6_R", 32'(lr[6]), 8);
        chk("entry6_K", 32'(lk[6]), 3);
        chk("entry7_cx_zero", 32'(lx[7]), 0);
        chk("entry7_R_zero", 32'(lr[7]), 0);
        chk("commit_keeps_cx", 32'(cur_x), 18);

        // commit and clear together: clear wins
        btn[CM] = 1'b1; btn[CL] = 1'b1; cyc(1);
        btn[CM] = 1'b0; btn[CL] = 1'b0; cyc(1);
        chk("clear_pending_busy", 32'(busy), 1);
        frame();
        chk("clear_count", 32'(count), 0);
        for (int i = 0; i < 7; i++) chk($sformatf("clr_entry%0d", i), 32'(lx[i]) + 32'(lr[i]), 0);
        chk("clear_keeps_cx", 32'(cur_x), 18);
        chk("clear_prev", 32'(prev_en), 1);

        // reset while a commit waits for frame_start
        press(CM);
        chk("midcommit_busy", 32'(busy), 1);
        reset = 1'b1; #2;
        chk("midrst_count", 32'(count), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_cx", 32'(cur_x), 160);
        chk("midrst_R", 32'(cur_r), 32);
        chk("midrst_prev", 32'(prev_en), 0);
        chk("midrst_e0", 32'(lx[0]), 0);
        sw0 = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(2);
        frame();
        chk("post_rst_count", 32'(count), 0);
        chk("post_rst_busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
